// File: rtl/dpd_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dpd_input_sequencer
//  Purpose  : Paces upstream IQ samples into the DPD neural-network input
//             buffer, one sample per inference. The buffer is primed with
//             MEMORY_DEPTH zero samples after reset. It is flushed with the
//             same number of zeros at the end of every frame. A watchdog
//             bounds the wait for each inference.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : clock
//    rst_n        : asynchronous active-low reset
//    enable       : permits a frame to start (sampled in IDLE / end of FLUSH)
//    s_i, s_q     : upstream IQ sample
//    s_valid      : upstream sample valid
//    s_ready      : sequencer accepts a sample (RUN state only)
//    buf_i, buf_q : sample written into the NN input buffer
//    buf_valid    : input buffer write strobe
//    nn_start     : single-cycle inference request
//    nn_done      : inference complete
//    frame_done   : single-cycle pulse on the last flush sample
//    timeout_err  : sticky watchdog flag (cleared only by reset)
//    state        : current FSM state encoding
// ============================================================================
module dpd_input_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 5,
  parameter int FRAME_LEN    = 1024,
  parameter int TIMEOUT      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_i,
  input  logic [DATA_WIDTH-1:0] s_q,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] buf_i,
  output logic [DATA_WIDTH-1:0] buf_q,
  output logic                  buf_valid,
  output logic                  nn_start,
  input  logic                  nn_done,
  output logic                  frame_done,
  output logic                  timeout_err,
  output logic [2:0]            state
);

  // Counter widths and terminal values
  localparam int FCW = $clog2(FRAME_LEN + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int PHW = $clog2(MEMORY_DEPTH + 1);

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_LEN);
  localparam logic [WDW-1:0] WD_LIMIT   = WDW'(TIMEOUT);
  localparam logic [PHW-1:0] PHASE_LAST = PHW'(MEMORY_DEPTH - 1);
  // With a single-tap buffer the first flush cycle is also the last one.
  localparam logic           FLUSH_ONE  = (MEMORY_DEPTH == 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRIME   = 3'd1,
    RUN     = 3'd2,
    WAIT_NN = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  state_t         st;
  logic           primed;     // buffer history holds valid (zero) taps
  logic           nn_issued;  // nn_start already raised for this sample
  logic [FCW-1:0] frame_cnt;  // samples accepted in current frame
  logic [WDW-1:0] wd_cnt;     // cycles elapsed since nn_start
  logic [PHW-1:0] phase_cnt;  // zero-sample index within PRIME / FLUSH

  logic [PHW-1:0] phase_inc;
  logic [WDW-1:0] wd_inc;
  logic           nn_done_ok;

  assign phase_inc = phase_cnt + PHW'(1);
  // The watchdog saturates instead of wrapping.
  assign wd_inc    = (wd_cnt == WD_LIMIT) ? wd_cnt : wd_cnt + WDW'(1);
  // nn_done is honoured only after the nn_start cycle has passed.
  assign nn_done_ok = nn_done && nn_issued && !nn_start;

  // s_ready is a pure decode of the state register.
  assign s_ready = (st == RUN);
  assign state   = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      primed      <= 1'b0;
      nn_issued   <= 1'b0;
      frame_cnt   <= '0;
      wd_cnt      <= '0;
      phase_cnt   <= '0;
      buf_valid   <= 1'b0;
      buf_i       <= '0;
      buf_q       <= '0;
      nn_start    <= 1'b0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Pulses default low. Each state raises them only where needed.
      nn_start   <= 1'b0;
      frame_done <= 1'b0;

      case (st)
        IDLE: begin
          buf_valid <= 1'b0;
          buf_i     <= '0;
          buf_q     <= '0;
          if (enable) begin
            if (primed) begin
              st        <= RUN;
              frame_cnt <= '0;
            end else begin
              // The zero strobe starts together with entry into PRIME.
              // PRIME therefore emits exactly MEMORY_DEPTH strobes.
              st        <= PRIME;
              phase_cnt <= '0;
              buf_valid <= 1'b1;
            end
          end
        end

        PRIME: begin
          buf_i <= '0;
          buf_q <= '0;
          if (phase_cnt == PHASE_LAST) begin
            buf_valid <= 1'b0;
            primed    <= 1'b1;
            frame_cnt <= '0;
            st        <= RUN;
          end else begin
            buf_valid <= 1'b1;
            phase_cnt <= phase_inc;
          end
        end

        RUN: begin
          if (s_valid) begin
            buf_valid <= 1'b1;
            buf_i     <= s_i;
            buf_q     <= s_q;
            if (frame_cnt != FRAME_LAST) begin
              frame_cnt <= frame_cnt + FCW'(1);
            end
            nn_issued <= 1'b0;
            wd_cnt    <= '0;
            st        <= WAIT_NN;
          end else begin
            buf_valid <= 1'b0;
            buf_i     <= '0;
            buf_q     <= '0;
          end
        end

        WAIT_NN: begin
          buf_valid <= 1'b0;
          buf_i     <= '0;
          buf_q     <= '0;
          if (!nn_issued) begin
            // The buffer registers the sample on this edge.
            // nn_start therefore lines up with the buffer's out_valid.
            nn_start  <= 1'b1;
            nn_issued <= 1'b1;
            wd_cnt    <= '0;
          end else if (nn_done_ok) begin
            if (frame_cnt == FRAME_LAST) begin
              st         <= FLUSH;
              phase_cnt  <= '0;
              buf_valid  <= 1'b1;
              frame_done <= FLUSH_ONE;
            end else begin
              st <= RUN;
            end
          end else begin
            wd_cnt <= wd_inc;
            if (wd_inc == WD_LIMIT) begin
              timeout_err <= 1'b1;
              st          <= FLUSH;
              phase_cnt   <= '0;
              buf_valid   <= 1'b1;
              frame_done  <= FLUSH_ONE;
            end
          end
        end

        FLUSH: begin
          buf_i <= '0;
          buf_q <= '0;
          if (phase_cnt == PHASE_LAST) begin
            buf_valid <= 1'b0;
            frame_cnt <= '0;
            st        <= enable ? RUN : IDLE;
          end else begin
            buf_valid  <= 1'b1;
            phase_cnt  <= phase_inc;
            // Registered one cycle early so the pulse sits on the last sample.
            frame_done <= (phase_inc == PHASE_LAST);
          end
        end

        default: begin
          st        <= IDLE;
          buf_valid <= 1'b0;
          buf_i     <= '0;
          buf_q     <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dpd_input_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpd_input_sequencer
//  Purpose  : Directed self-checking bench for dpd_input_sequencer
//             (MEMORY_DEPTH=5, FRAME_LEN=4, TIMEOUT=16)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dpd_input_sequencer;

  localparam int DW = 16;
  localparam int MD = 5;
  localparam int FL = 4;
  localparam int TO = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b1;
  logic          enable  = 1'b0;
  logic          s_valid = 1'b0;
  logic          nn_done = 1'b0;
  logic [DW-1:0] s_i     = '0;
  logic [DW-1:0] s_q     = '0;

  logic          s_ready;
  logic [DW-1:0] buf_i;
  logic [DW-1:0] buf_q;
  logic          buf_valid;
  logic          nn_start;
  logic          frame_done;
  logic          timeout_err;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpd_input_sequencer #(
    .DATA_WIDTH  (DW),
    .MEMORY_DEPTH(MD),
    .FRAME_LEN   (FL),
    .TIMEOUT     (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .s_i        (s_i),
    .s_q        (s_q),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .buf_i      (buf_i),
    .buf_q      (buf_q),
    .buf_valid  (buf_valid),
    .nn_start   (nn_start),
    .nn_done    (nn_done),
    .frame_done (frame_done),
    .timeout_err(timeout_err),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Accepts one sample at edge T.
  // Returns at the negedge after T+1, while nn_start is high.
  task automatic send_sample(input logic [DW-1:0] i, input logic [DW-1:0] q);
    s_i     = i;
    s_q     = q;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("smp_buf_valid", 32'(buf_valid), 32'd1);
    check("smp_buf_i", 32'(buf_i), 32'(i));
    check("smp_buf_q", 32'(buf_q), 32'(q));
    check("smp_state_wait", 32'(state), 32'(S_WAIT));
    check("smp_s_ready_low", 32'(s_ready), 32'd0);
    check("smp_nn_start_early", 32'(nn_start), 32'd0);
    step();
    check("smp_nn_start", 32'(nn_start), 32'd1);
    check("smp_buf_valid_drop", 32'(buf_valid), 32'd0);
  endtask

  // nn_done is sampled at edge T+3, the first edge at which it is honoured.
  task automatic done_at_t3();
    step();
    check("done_nn_start_single", 32'(nn_start), 32'd0);
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
  endtask

  // Walks the MD flush cycles, checking zero data and the final frame_done.
  task automatic flush_check();
    for (int k = 0; k < MD; k++) begin
      check("flush_state", 32'(state), 32'(S_FLUSH));
      check("flush_buf_valid", 32'(buf_valid), 32'd1);
      check("flush_data_zero", {buf_i, buf_q}, 32'd0);
      check("flush_no_nn_start", 32'(nn_start), 32'd0);
      check("flush_frame_done", 32'(frame_done), (k == MD - 1) ? 32'd1 : 32'd0);
      step();
    end
    check("flush_frame_done_clear", 32'(frame_done), 32'd0);
  endtask

  task automatic prime_check();
    for (int k = 0; k < MD; k++) begin
      check("prime_state", 32'(state), 32'(S_PRIME));
      check("prime_buf_valid", 32'(buf_valid), 32'd1);
      check("prime_data_zero", {buf_i, buf_q}, 32'd0);
      check("prime_s_ready", 32'(s_ready), 32'd0);
      step();
    end
    check("prime_to_run", 32'(state), 32'(S_RUN));
    check("run_s_ready", 32'(s_ready), 32'd1);
    check("run_buf_valid_low", 32'(buf_valid), 32'd0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 rst_n = 1'b0;
    step();
    step();
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_buf_valid", 32'(buf_valid), 32'd0);
    check("rst_buf_data", {buf_i, buf_q}, 32'd0);
    check("rst_nn_start", 32'(nn_start), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // ---------------- prime after reset release ----------------
    rst_n  = 1'b1;
    enable = 1'b1;
    step();
    prime_check();

    // ---------------- spurious nn_done in RUN ----------------
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("spurious_done_state", 32'(state), 32'(S_RUN));
    check("spurious_done_nn_start", 32'(nn_start), 32'd0);

    // ---------------- frame A: four prompt samples ----------------
    send_sample(16'h1234, 16'hEDCC);
    done_at_t3();
    check("a1_back_to_run", 32'(state), 32'(S_RUN));
    check("a1_s_ready", 32'(s_ready), 32'd1);

    // An nn_done during the nn_start cycle must be ignored.
    send_sample(16'h0001, 16'hFFFF);
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("a2_early_done_ignored", 32'(state), 32'(S_WAIT));
    check("a2_s_ready_low", 32'(s_ready), 32'd0);
    nn_done = 1'b1;
    step();
    nn_done = 1'b0;
    check("a2_back_to_run", 32'(state), 32'(S_RUN));

    send_sample(16'h7FFF, 16'h8000);
    done_at_t3();
    check("a3_back_to_run", 32'(state), 32'(S_RUN));

    send_sample(16'h5A5A, 16'hA5A5);
    done_at_t3();
    check("a4_to_flush", 32'(state), 32'(S_FLUSH));
    flush_check();
    check("a_next_frame_run", 32'(state), 32'(S_RUN));
    check("a_next_s_ready", 32'(s_ready), 32'd1);
    check("a_no_timeout", 32'(timeout_err), 32'd0);

    // ---------------- frame B: watchdog ----------------
    send_sample(16'h0ABC, 16'h0DEF);  // negedge after T+1, nn_start high
    step();                           // after T+2
    check("b_nn_start_single", 32'(nn_start), 32'd0);
    repeat (14) step();               // after T+16
    check("b_no_timeout_yet", 32'(timeout_err), 32'd0);
    check("b_still_waiting", 32'(state), 32'(S_WAIT));
    step();                           // after T+17 = 16 cycles after nn_start
    check("b_timeout_set", 32'(timeout_err), 32'd1);
    check("b_timeout_flush", 32'(state), 32'(S_FLUSH));
    flush_check();
    check("b_next_frame_run", 32'(state), 32'(S_RUN));
    check("b_timeout_sticky", 32'(timeout_err), 32'd1);

    // ---------------- frame C: enable dropped mid-frame ----------------
    send_sample(16'h1111, 16'h2222);
    done_at_t3();
    send_sample(16'h3333, 16'h4444);
    done_at_t3();
    enable = 1'b0;
    check("c2_run_after_disable", 32'(state), 32'(S_RUN));
    send_sample(16'h5555, 16'h6666);
    done_at_t3();
    check("c3_run", 32'(state), 32'(S_RUN));
    send_sample(16'h7777, 16'h8888);
    done_at_t3();
    check("c4_to_flush", 32'(state), 32'(S_FLUSH));
    flush_check();
    check("c_idle_after_flush", 32'(state), 32'(S_IDLE));
    check("c_idle_s_ready", 32'(s_ready), 32'd0);
    check("c_timeout_sticky", 32'(timeout_err), 32'd1);
    step();
    check("c_idle_holds", 32'(state), 32'(S_IDLE));

    // Already primed: IDLE goes straight to RUN.
    enable = 1'b1;
    step();
    check("reenable_primed_run", 32'(state), 32'(S_RUN));

    // ---------------- reset during WAIT_NN ----------------
    s_i     = 16'hBEEF;
    s_q     = 16'hCAFE;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("r_wait_state", 32'(state), 32'(S_WAIT));
    check("r_in_flight", 32'(buf_valid), 32'd1);
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("r_async_state", 32'(state), 32'(S_IDLE));
    check("r_async_buf_valid", 32'(buf_valid), 32'd0);
    check("r_async_buf_data", {buf_i, buf_q}, 32'd0);
    check("r_async_nn_start", 32'(nn_start), 32'd0);
    check("r_async_s_ready", 32'(s_ready), 32'd0);
    check("r_async_timeout", 32'(timeout_err), 32'd0);
    check("r_async_frame_done", 32'(frame_done), 32'd0);
    step();
    check("r_held_nn_start", 32'(nn_start), 32'd0);
    rst_n = 1'b1;
    step();
    check("r_post_nn_start_1", 32'(nn_start), 32'd0);
    step();
    check("r_post_nn_start_2", 32'(nn_start), 32'd0);
    check("r_post_idle", 32'(state), 32'(S_IDLE));

    // Reset cleared primed, so PRIME must run again.
    enable = 1'b1;
    step();
    prime_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
